// File: rtl/servo_pkg.sv
// Shared constants for the servo PWM bank: default timing (20 ms frame at
// 50 MHz, 1 ms to ~2 ms pulse) and channel geometry.
package servo_pkg;

  localparam int DEF_FRAME_CLKS = 1000000;
  localparam int DEF_MIN_CLKS   = 50000;
  localparam int DEF_STEP_CLKS  = 196;
  localparam int DEF_CNT_W      = 20;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int POS_W  = 8;

endpackage

// File: rtl/servo_pwm_bank_channel.sv
// One servo channel: double-buffered position, pulse width committed at the
// frame boundary, and the registered pulse comparator.
module servo_channel
  import servo_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MIN_CLKS  = DEF_MIN_CLKS,
  parameter int STEP_CLKS = DEF_STEP_CLKS
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_wr,
  input  logic [POS_W-1:0] i_wr_pos,
  input  logic             i_commit,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pad,
  output logic             o_armed
);

  localparam logic [CNT_W-1:0] MIN_W  = CNT_W'(MIN_CLKS);
  localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP_CLKS);

  logic [POS_W-1:0] r_shadow;
  logic             r_pending;
  logic             r_armed;
  logic [CNT_W-1:0] r_width;
  logic             r_pad;

  logic [POS_W-1:0] w_pos;
  logic [CNT_W-1:0] w_width;

  // A write landing in the commit cycle is forwarded straight into the commit.
  assign w_pos   = i_wr ? i_wr_pos : r_shadow;
  assign w_width = MIN_W + CNT_W'(w_pos) * STEP_W;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_armed   <= 1'b0;
      r_width   <= '0;
      r_pad     <= 1'b0;
    end else begin
      if (i_wr) begin
        r_shadow <= i_wr_pos;
      end
      if (i_commit && (r_pending || i_wr)) begin
        r_width   <= w_width;
        r_armed   <= 1'b1;
        r_pending <= 1'b0;
      end else if (i_wr) begin
        r_pending <= 1'b1;
      end
      r_pad <= r_armed && (i_cnt < r_width);
    end
  end

  assign o_pad   = r_pad;
  assign o_armed = r_armed;

endmodule

// File: rtl/servo_pwm_bank.sv
// Eight-channel hobby-servo PWM bank: shared frame counter, write decode and
// one servo_channel per pad bit.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int FRAME_CLKS = DEF_FRAME_CLKS,
  parameter int MIN_CLKS   = DEF_MIN_CLKS,
  parameter int STEP_CLKS  = DEF_STEP_CLKS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [CH_W-1:0]   i_wr_chan,
  input  logic [POS_W-1:0]  i_wr_pos,
  output logic [NUM_CH-1:0] o_servo_pad,
  output logic              o_frame_start,
  output logic [NUM_CH-1:0] o_armed
);

  if (longint'(FRAME_CLKS) > (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("servo_pwm_bank: FRAME_CLKS does not fit in CNT_W bits");
  end
  if (longint'(MIN_CLKS) + 255 * longint'(STEP_CLKS) >= longint'(FRAME_CLKS)) begin : g_bad_width
    $error("servo_pwm_bank: longest pulse does not fit inside one frame");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CLKS - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_started;
  logic              w_commit;
  logic [NUM_CH-1:0] w_wr;

  assign w_commit = (r_cnt == LAST_CNT);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_started <= 1'b0;
    end else begin
      r_cnt     <= w_commit ? '0 : r_cnt + CNT_W'(1);
      r_started <= 1'b1;
    end
  end

  // The counter sits at zero through reset, so the release cycle is not a frame start.
  assign o_frame_start = r_started && (r_cnt == '0);

  always_comb begin
    w_wr = '0;
    if (i_wr_en) begin
      w_wr[i_wr_chan] = 1'b1;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    servo_channel #(
      .CNT_W    (CNT_W),
      .MIN_CLKS (MIN_CLKS),
      .STEP_CLKS(STEP_CLKS)
    ) u_ch (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_wr    (w_wr[n]),
      .i_wr_pos(i_wr_pos),
      .i_commit(w_commit),
      .i_cnt   (r_cnt),
      .o_pad   (o_servo_pad[n]),
      .o_armed (o_armed[n])
    );
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: directed scenarios plus random writes, checked
// every cycle against a frame-level model of pulse widths and commits.
module tb_servo_pwm_bank;

  localparam int FRAME = 1000;
  localparam int MIN   = 100;
  localparam int STEP  = 2;
  localparam int CW    = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_chan = '0;
  logic [7:0] wr_pos = '0;
  logic [7:0] pad;
  logic [7:0] armed;
  logic       fs;

  int n_err = 0;
  int n_chk = 0;

  servo_pwm_bank #(
    .FRAME_CLKS(FRAME),
    .MIN_CLKS  (MIN),
    .STEP_CLKS (STEP),
    .CNT_W     (CW)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_wr_en      (wr_en),
    .i_wr_chan    (wr_chan),
    .i_wr_pos     (wr_pos),
    .o_servo_pad  (pad),
    .o_frame_start(fs),
    .o_armed      (armed)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: time since reset release; positions written this frame; widths
  // in force for the current frame. A pulse occupies frame positions 1..width.
  bit m_valid = 1'b0;
  bit m_fresh = 1'b1;
  int m_t = 0;
  int m_q;
  int m_nxt[8];
  bit m_set[8];
  int m_width[8];
  bit m_armed[8];

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_fresh = 1'b1;
      m_t     = 0;
      for (int n = 0; n < 8; n++) begin
        m_nxt[n] = 0; m_set[n] = 1'b0; m_width[n] = 0; m_armed[n] = 1'b0;
      end
    end else if (m_valid) begin
      m_q = m_t % FRAME;
      if (wr_en) begin
        m_nxt[wr_chan] = int'(wr_pos);
        m_set[wr_chan] = 1'b1;
      end
      if (m_q == FRAME - 1) begin
        for (int n = 0; n < 8; n++) begin
          if (m_set[n]) begin
            m_width[n] = MIN + m_nxt[n] * STEP;
            m_armed[n] = 1'b1;
            m_set[n]   = 1'b0;
          end
        end
      end
      m_t++;
      m_fresh = 1'b0;
    end
  end

  int         c_q;
  logic [7:0] c_pad;
  logic [7:0] c_arm;
  int         n_cyc = 0;
  int         prev_fs = 0;
  bit         have_prev = 1'b0;

  always @(negedge clk) begin
    n_cyc++;
    if (m_valid) begin
      c_q = m_t % FRAME;
      for (int n = 0; n < 8; n++) begin
        c_pad[n] = m_armed[n] && (c_q >= 1) && (c_q <= m_width[n]);
        c_arm[n] = m_armed[n];
      end
      check_eq("pad", 32'(pad), 32'(c_pad));
      check_eq("armed", 32'(armed), 32'(c_arm));
      check_eq("frame_start", 32'(fs), 32'((c_q == 0) && !m_fresh));
    end
    if (rst) begin
      have_prev = 1'b0;
    end else if (fs) begin
      if (have_prev) check_eq("fs_spacing", 32'(n_cyc - prev_fs), 32'(FRAME));
      prev_fs   = n_cyc;
      have_prev = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int p);
    int g = 0;
    while ((m_t % FRAME) != p && g < 3 * FRAME) begin
      tick();
      g++;
    end
    check_eq("wait_bound", 32'(g >= 3 * FRAME), 32'(0));
  endtask

  task automatic write(input int ch, input int pos);
    wr_en   = 1'b1;
    wr_chan = 3'(ch);
    wr_pos  = 8'(pos);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic run_frames(input int k);
    repeat (k * FRAME) tick();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Idle frames: no pulses, no arming.
    run_frames(3);
    check_eq("idle_armed", 32'(armed), 32'h00);

    // ch0 pos 0 -> 100 clocks starting at position 1.
    wait_pos(300); write(0, 0);
    wait_pos(1);   check_eq("s2_armed", 32'(armed), 32'h01);
                   check_eq("s2_rise", 32'(pad[0]), 32'd1);
    wait_pos(100); check_eq("s2_last", 32'(pad[0]), 32'd1);
    wait_pos(101); check_eq("s2_fall", 32'(pad[0]), 32'd0);

    // ch3 pos 255 -> 610 clocks.
    wait_pos(700); write(3, 255);
    wait_pos(610); check_eq("s3_last", 32'(pad[3]), 32'd1);
    wait_pos(611); check_eq("s3_fall", 32'(pad[3]), 32'd0);
                   check_eq("s3_armed", 32'(armed), 32'h09);

    // Two writes during ch0's pulse: current pulse unchanged, last write wins.
    wait_pos(50);  write(0, 50);
    wait_pos(60);  write(0, 20);
    wait_pos(100); check_eq("s4_cur_last", 32'(pad[0]), 32'd1);
    wait_pos(101); check_eq("s4_cur_fall", 32'(pad[0]), 32'd0);
    wait_pos(0);
    wait_pos(140); check_eq("s4_new_last", 32'(pad[0]), 32'd1);
    wait_pos(141); check_eq("s4_new_fall", 32'(pad[0]), 32'd0);

    // Write in the commit cycle lands in the very next frame.
    wait_pos(999); write(5, 10);
    check_eq("s5_armed", 32'(armed), 32'h29);
    wait_pos(120); check_eq("s5_last", 32'(pad[5]), 32'd1);
    wait_pos(121); check_eq("s5_fall", 32'(pad[5]), 32'd0);

    // One-cycle reset in the middle of ch3's pulse.
    wait_pos(0);
    wait_pos(50);  check_eq("s6_pre", 32'(pad[3]), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("s6_pad", 32'(pad), 32'h00);
    check_eq("s6_armed", 32'(armed), 32'h00);
    run_frames(2);
    check_eq("s6_still_unarmed", 32'(armed), 32'h00);

    // Random writes, including the occasional commit-cycle write.
    repeat (8 * FRAME) begin
      if ($urandom_range(0, 39) == 0 || ((m_t % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 1)) begin
        wr_en   = 1'b1;
        wr_chan = 3'($urandom_range(0, 7));
        wr_pos  = 8'($urandom_range(0, 255));
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    run_frames(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
